// File: rtl/regfile_bypass_sb.sv
// Register file with two write ports, two combinational read ports with
// write-first bypass, and a scoreboard of pending destination registers.
// Register 0 is hardwired to zero and is never pending. Port B wins over
// port A when both write the same register in one cycle.
module regfile_bypass_sb #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int AW   = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wen_a,
   input  logic            wen_b,
   input  logic [AW-1:0]   wa_a,
   input  logic [AW-1:0]   wa_b,
   input  logic [XLEN-1:0] wd_a,
   input  logic [XLEN-1:0] wd_b,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rd,
   output logic            busy1,
   output logic            busy2,
   output logic            quiet,
   output logic [AW:0]     busy_count
);

   logic [XLEN-1:0] regs [NREG];
   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_nxt;
   logic [AW:0]     count_nxt;

   logic wr_a, wr_b, iss;
   logic hit_a1, hit_b1, hit_a2, hit_b2;

   assign wr_a = wen_a && (wa_a != '0);
   assign wr_b = wen_b && (wa_b != '0);
   assign iss  = issue_valid && (issue_rd != '0);

   assign hit_a1 = wr_a && (wa_a == rs1);
   assign hit_b1 = wr_b && (wa_b == rs1);
   assign hit_a2 = wr_a && (wa_a == rs2);
   assign hit_b2 = wr_b && (wa_b == rs2);

   // Read ports: zero register, then port B bypass, port A bypass, storage.
   always_comb begin
      rd1 = regs[rs1];
      if (rs1 == '0)  rd1 = '0;
      else if (hit_b1) rd1 = wd_b;
      else if (hit_a1) rd1 = wd_a;

      rd2 = regs[rs2];
      if (rs2 == '0)  rd2 = '0;
      else if (hit_b2) rd2 = wd_b;
      else if (hit_a2) rd2 = wd_a;
   end

   // Storage update; port B is applied last so it overrides port A.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         if (wr_a) regs[wa_a] <= wd_a;
         if (wr_b) regs[wa_b] <= wd_b;
      end
   end

   // Next busy vector: writes clear first, a new issue then sets, so a new
   // producer supersedes a same-cycle completion.
   always_comb begin
      busy_nxt = busy;
      if (wr_a) busy_nxt[wa_a] = 1'b0;
      if (wr_b) busy_nxt[wa_b] = 1'b0;
      if (iss)  busy_nxt[issue_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
      count_nxt = '0;
      for (int i = 0; i < NREG; i++)
         count_nxt = count_nxt + {{AW{1'b0}}, busy_nxt[i]};
   end

   // Scoreboard state and its registered population count.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy       <= '0;
         busy_count <= '0;
      end else begin
         busy       <= busy_nxt;
         busy_count <= count_nxt;
      end
   end

   // A source being written this cycle is no longer waiting on its producer.
   always_comb begin
      busy1 = (rs1 != '0) && busy[rs1] && !(hit_a1 || hit_b1);
      busy2 = (rs2 != '0) && busy[rs2] && !(hit_a2 || hit_b2);
   end

   assign quiet = (busy_count == '0);

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Directed bench for regfile_bypass_sb: bypass, port priority, zero
// register, scoreboard set/clear rules and reset priority.
module tb_regfile_bypass_sb;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int AW   = 5;

   logic            clk;
   logic            rst;
   logic            wen_a, wen_b;
   logic [AW-1:0]   wa_a, wa_b;
   logic [XLEN-1:0] wd_a, wd_b;
   logic [AW-1:0]   rs1, rs2;
   logic [XLEN-1:0] rd1, rd2;
   logic            issue_valid;
   logic [AW-1:0]   issue_rd;
   logic            busy1, busy2, quiet;
   logic [AW:0]     busy_count;

   int n_tests = 0;
   int n_fail  = 0;

   regfile_bypass_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) dut (
      .clk(clk), .rst(rst),
      .wen_a(wen_a), .wen_b(wen_b),
      .wa_a(wa_a), .wa_b(wa_b),
      .wd_a(wd_a), .wd_b(wd_b),
      .rs1(rs1), .rs2(rs2),
      .rd1(rd1), .rd2(rd2),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .busy1(busy1), .busy2(busy2),
      .quiet(quiet), .busy_count(busy_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge; inputs then change mid-cycle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wen_a = 0; wen_b = 0; wa_a = 0; wa_b = 0; wd_a = 0; wd_b = 0;
      issue_valid = 0; issue_rd = 0;
   endtask

   initial begin
      idle();
      rs1 = 0; rs2 = 0;
      rst = 1;
      tick(); tick();
      rst = 0;

      // Reset state
      rs1 = 5; #1;
      check_val("rst_rd1", rd1, 32'h0);
      check_val("rst_busy1", busy1, 1'b0);
      check_val("rst_quiet", quiet, 1'b1);
      check_val("rst_count", busy_count, 0);

      // Write-first bypass then stored value
      wen_a = 1; wa_a = 5; wd_a = 32'hDEADBEEF; #1;
      check_val("byp_a", rd1, 32'hDEADBEEF);
      tick(); idle(); #1;
      check_val("stored_a", rd1, 32'hDEADBEEF);

      // Port B priority on same address
      wen_a = 1; wa_a = 7; wd_a = 32'h11;
      wen_b = 1; wa_b = 7; wd_b = 32'h22;
      rs1 = 7; rs2 = 7; #1;
      check_val("prio_byp1", rd1, 32'h22);
      check_val("prio_byp2", rd2, 32'h22);
      tick(); idle(); #1;
      check_val("prio_st1", rd1, 32'h22);
      check_val("prio_st2", rd2, 32'h22);

      // Issue then completion on port B
      issue_valid = 1; issue_rd = 3;
      tick(); idle();
      rs2 = 3; #1;
      check_val("iss_busy2", busy2, 1'b1);
      check_val("iss_count", busy_count, 1);
      check_val("iss_quiet", quiet, 1'b0);
      wen_b = 1; wa_b = 3; wd_b = 32'h33; #1;
      check_val("wb_busy2_same", busy2, 1'b0);
      check_val("wb_rd2_byp", rd2, 32'h33);
      tick(); idle(); #1;
      check_val("wb_count", busy_count, 0);
      check_val("wb_quiet", quiet, 1'b1);
      check_val("wb_busy2", busy2, 1'b0);

      // Set wins over clear on a pending register
      issue_valid = 1; issue_rd = 4;
      tick(); idle(); #1;
      check_val("r4_count", busy_count, 1);
      issue_valid = 1; issue_rd = 4;
      wen_a = 1; wa_a = 4; wd_a = 32'h44;
      tick(); idle();
      rs1 = 4; #1;
      check_val("setwin_busy1", busy1, 1'b1);
      check_val("setwin_count", busy_count, 1);
      check_val("setwin_rd1", rd1, 32'h44);

      // Register 0 ignores writes and issues
      wen_a = 1; wa_a = 0; wd_a = 32'hFFFFFFFF;
      issue_valid = 1; issue_rd = 0;
      rs1 = 0; #1;
      check_val("z_rd1_byp", rd1, 32'h0);
      check_val("z_busy1", busy1, 1'b0);
      tick(); idle(); #1;
      check_val("z_rd1", rd1, 32'h0);
      check_val("z_count", busy_count, 1);

      // Two clears and one set in the same cycle
      issue_valid = 1; issue_rd = 9;
      tick(); idle(); #1;
      check_val("two_pend", busy_count, 2);
      wen_a = 1; wa_a = 4; wd_a = 32'h4;
      wen_b = 1; wa_b = 9; wd_b = 32'h9;
      issue_valid = 1; issue_rd = 10;
      tick(); idle();
      rs1 = 10; rs2 = 4; #1;
      check_val("mix_count", busy_count, 1);
      check_val("mix_busy1", busy1, 1'b1);
      check_val("mix_busy2", busy2, 1'b0);
      rs2 = 9; #1;
      check_val("mix_busy9", busy2, 1'b0);

      // Write to a non-pending register leaves count alone
      wen_a = 1; wa_a = 12; wd_a = 32'hC;
      tick(); idle();
      rs1 = 12; #1;
      check_val("npw_count", busy_count, 1);
      check_val("npw_busy1", busy1, 1'b0);

      // Re-issue to an already pending register
      issue_valid = 1; issue_rd = 10;
      tick(); idle();
      rs1 = 10; #1;
      check_val("reiss_count", busy_count, 1);
      check_val("reiss_busy1", busy1, 1'b1);

      // Reset beats same-cycle write and issue; bypass still visible
      rst = 1;
      wen_a = 1; wa_a = 5; wd_a = 32'h55;
      issue_valid = 1; issue_rd = 11;
      rs1 = 5; rs2 = 7; #1;
      check_val("rst_byp", rd1, 32'h55);
      tick(); idle();
      rst = 0;
      rs2 = 11; #1;
      check_val("rst_rd5", rd1, 32'h0);
      check_val("rst2_count", busy_count, 0);
      check_val("rst2_quiet", quiet, 1'b1);
      check_val("rst2_busy11", busy2, 1'b0);
      rs2 = 7; #1;
      check_val("rst_rd7", rd2, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
